// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the scanned debounce controller.
// Optional auto-repeat is enabled with DEBOUNCE_SCAN_AUTOREPEAT_EN.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int unsigned MIN_W = 1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : MIN_W;
  endfunction

endpackage

// File: rtl/debounce_scan_ctrl_tick_prescaler.sv
// Sample-tick prescaler shared by all debounce channels.
// Optional auto-repeat is enabled with DEBOUNCE_SCAN_AUTOREPEAT_EN.
module tick_prescaler
  import debounce_pkg::*;
#(
  parameter int TICK_CYCLES = 100000
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int PW = cw(TICK_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    tick_out = (cnt_q == LAST);
    cnt_d    = tick_out ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// N-channel debouncer with one shared compare/count engine scanned per tick.
// Optional auto-repeat is enabled with DEBOUNCE_SCAN_AUTOREPEAT_EN.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_CYCLES  = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_TICKS = 250
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] bouncey_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] press_out,
  output logic [N_CH-1:0] release_out,
  output logic            scanning_out,
  output logic            overrun_out
);

  localparam int IW = cw(N_CH);
  localparam int CW = cw(STABLE_TICKS);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic tick;

  logic [N_CH-1:0] meta_q;
  logic [N_CH-1:0] sync_q;
  scan_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] clean_q, clean_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic            ovr_q, ovr_d;
  logic            cur_sync;
  logic            cur_clean;

`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
  localparam int RW = cw(REPEAT_TICKS);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rpt_q [N_CH];
  logic [RW-1:0] rpt_d [N_CH];
  logic          accept;
`endif

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_presc (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = '0;
    rel_d     = '0;
    ovr_d     = ovr_q | (tick & (state_q == SCAN));
    cur_sync  = sync_q[idx_q];
    cur_clean = clean_q[idx_q];
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
    rpt_d     = rpt_q;
    accept    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (cur_sync == cur_clean) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == CNT_LAST) begin
          clean_d[idx_q] = cur_sync;
          cnt_d[idx_q]   = '0;
          press_d[idx_q] = cur_sync;
          rel_d[idx_q]   = ~cur_sync;
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
          accept = 1'b1;
`endif
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
        end
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
        // A held key re-fires press in its own slot every REPEAT_TICKS visits.
        if (accept && cur_sync) begin
          rpt_d[idx_q] = '0;
        end else if (cur_clean && !accept) begin
          if (rpt_q[idx_q] == RPT_LAST) begin
            press_d[idx_q] = 1'b1;
            rpt_d[idx_q]   = '0;
          end else begin
            rpt_d[idx_q] = rpt_q[idx_q] + 1'b1;
          end
        end
`endif
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q  <= '0;
      sync_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '{default: '0};
      clean_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      ovr_q   <= 1'b0;
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
      rpt_q   <= '{default: '0};
`endif
    end else begin
      meta_q  <= bouncey_in;
      sync_q  <= meta_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      ovr_q   <= ovr_d;
`ifdef DEBOUNCE_SCAN_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign clean_out    = clean_q;
  assign press_out    = press_q;
  assign release_out  = rel_q;
  assign scanning_out = (state_q == SCAN);
  assign overrun_out  = ovr_q;

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
Multi-channel debounce controller that shares one sample-tick prescaler and one compare/count engine across N_CH button inputs.
A scan FSM visits channels round-robin, one per clock, on each sample tick, and keeps per-channel state in register arrays.
It publishes clean levels plus single-cycle press/release events.
It sits between the board's raw button and switch pins and the user logic, replacing N independent debouncers.

Parameters:
N_CH, 4, number of input channels (2..16)
TICK_CYCLES, 100000, clocks per sample tick (1 ms at 100 MHz); must be >= N_CH+2
STABLE_TICKS, 10, consecutive disagreeing samples required to accept a new level
REPEAT_TICKS, 250, auto-repeat interval in ticks (used only with the optional feature)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
bouncey_in  input  N_CH  raw asynchronous button levels
clean_out  output  N_CH  debounced levels
press_out  output  N_CH  one-cycle pulse on an accepted 0->1 transition (or auto-repeat)
release_out  output  N_CH  one-cycle pulse on an accepted 1->0 transition
scanning_out  output  1  high while the FSM is in SCAN
overrun_out  output  1  sticky flag; a tick arrived while SCAN was still active

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Synchronizer: each bouncey_in bit passes through a 2-flop synchronizer, giving sync[i].
- Prescaler: counter runs 0..TICK_CYCLES-1. tick=1 for the single cycle when the counter equals TICK_CYCLES-1, then the counter wraps to 0.
- FSM states:
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: process channel idx each cycle. After idx==N_CH-1, go to IDLE.
- Per-channel processing, in the cycle idx=i:
  - If sync[i]==clean[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i]==STABLE_TICKS-1: clean[i] <= sync[i], cnt[i] <= 0, and pulse press[i] if sync[i]=1, else release[i].
  - Otherwise: cnt[i] <= cnt[i]+1.
- Counter width: cnt width = $clog2(STABLE_TICKS). cnt saturates logically and never wraps.
- Timing: if tick is high in cycle T, channel i is evaluated in cycle T+1+i. clean_out, press_out and release_out change at the clock edge ending that cycle, so they are visible in cycle T+2+i.
- Pulse width: press_out/release_out are exactly 1 cycle wide. Pulses on different channels occur in different cycles.
- Bounce handling: input returns to the clean level before the count completes -> cnt clears and no event is produced.
- Overrun: tick while in SCAN (only possible if the parameter rule is violated) sets overrun_out. The tick is dropped and the current scan completes.
- Reset:
  - Asserted at any time, including mid-scan.
  - Next cycle: FSM=IDLE, idx=0, prescaler=0, all cnt=0, clean_out=0, press_out=0, release_out=0, scanning_out=0, overrun_out=0, synchronizer flops=0.
  - No event pulses are emitted for inputs already high at reset; they produce a press after STABLE_TICKS ticks.
- scanning_out: equals (state==SCAN).

Optional Feature:
Macro: DEBOUNCE_SCAN_AUTOREPEAT_EN
- Defined:
  - Per-channel repeat counter rpt[i], width $clog2(REPEAT_TICKS).
  - Cleared on an accepted press.
  - While clean[i]=1, incremented at each visit of channel i.
  - When it reaches REPEAT_TICKS-1: press_out[i] pulses again (same timing slot) and rpt[i] clears.
  - Reset clears all rpt.
- Undefined: no rpt storage; press_out fires once per accepted press.

Decomposition:
- Package debounce_pkg holds the scan_state_t enum (IDLE, SCAN) and the tick/index width helper localparams.
- One natural sub-module, tick_prescaler: TICK_CYCLES counter with a tick output, reset by rst_in.
- Synchronizer and FSM stay in the top module.

Test Plan:
Bench parameters: N_CH=4, TICK_CYCLES=10, STABLE_TICKS=4, REPEAT_TICKS=3.
1. Reset release with all inputs 0 -> no pulses and clean_out=0 for 200 cycles. Tick every 10 cycles. scanning_out high for 4 cycles per tick.
2. Hold bouncey_in[2]=1 steadily -> clean_out[2] rises on the 4th tick after the synchronized value is seen. press_out[2] is one cycle wide, in cycle T+4 of that tick.
3. Toggle bouncey_in[1] every 15 cycles for 300 cycles -> no press/release, clean_out[1]=0. Then hold it at 0 -> still no events.
4. Set channels 0 and 3 high in the same cycle -> both accepted on the same tick. press_out[0] in cycle T+2, press_out[3] in cycle T+5. Release both -> matching release pulses.
5. Assert rst_in for 1 cycle mid-scan with clean_out=4'b0100 -> all outputs 0 next cycle. Channel 2, still held, re-presses after 4 ticks.
6. With DEBOUNCE_SCAN_AUTOREPEAT_EN, hold channel 0 -> initial press, then press_out[0] repeats every 3 ticks. Undefined build: exactly one press.
